// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU control codes,
// R-type decode fields and the controller state type.
package alu_pkg;

  // ALU control codes driven to the datapath
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Only R-type register/register operations are issued
  localparam logic [6:0] OPCODE_R = 7'b0110011;

  // funct3 selectors
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // funct7 selectors: base encoding and the SUB alternate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Issue sequence states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_ctl_decoder.sv
// Combinational R-type decoder: maps opcode/funct3/funct7 onto an ALU
// control code and flags every encoding outside the supported set.
module alu_ctl_decoder
  import alu_pkg::*;
#(
  parameter logic [6:0] OPCODE = alu_pkg::OPCODE_R
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] control,
  output logic       illegal
);

  // Decode table; control is a don't-care whenever illegal is set
  always_comb begin
    control = ALU_ADD;
    illegal = 1'b1;
    if (opcode == OPCODE) begin
      if (funct3 == F3_ADDSUB && funct7 == F7_BASE) begin
        control = ALU_ADD;
        illegal = 1'b0;
      end else if (funct3 == F3_ADDSUB && funct7 == F7_ALT) begin
        control = ALU_SUB;
        illegal = 1'b0;
      end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
        control = ALU_AND;
        illegal = 1'b0;
      end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
        control = ALU_OR;
        illegal = 1'b0;
      end else if (funct3 == F3_SLT && funct7 == F7_BASE) begin
        control = ALU_SLT;
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_issue_controller.sv
// Issue controller for the register-file + ALU datapath. Accepts one R-type
// instruction at a time, holds operands/control for EXEC_CYCLES of ALU settle
// time, pulses the write enable, then reports completion with the Zero flag.
module alu_issue_controller
  import alu_pkg::*;
#(
  parameter int         EXEC_CYCLES = 1,
  parameter logic [6:0] OPCODE_R    = alu_pkg::OPCODE_R
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic [4:0]  ReadReg1,
  output logic [4:0]  ReadReg2,
  output logic [4:0]  WriteReg,
  output logic [3:0]  Control,
  output logic        RegWrite,
  output logic        DoneValid,
  output logic        DoneZero,
  output logic        Illegal
);

  localparam int            CW       = $clog2(EXEC_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;
  logic [4:0]      rd_reg;
  logic [3:0]      ctl_reg;
  logic            illegal_reg;
  logic            zero_reg;

  logic [3:0]      dec_control;
  logic            dec_illegal;

  alu_ctl_decoder #(
    .OPCODE (OPCODE_R)
  ) u_decoder (
    .opcode  (Instr[6:0]),
    .funct3  (Instr[14:12]),
    .funct7  (Instr[31:25]),
    .control (dec_control),
    .illegal (dec_illegal)
  );

  // Issue FSM, settle counter and latched instruction fields
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      rd_reg      <= '0;
      ctl_reg     <= '0;
      illegal_reg <= 1'b0;
      zero_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (InstrValid) begin
            rs1_reg     <= Instr[19:15];
            rs2_reg     <= Instr[24:20];
            rd_reg      <= Instr[11:7];
            illegal_reg <= dec_illegal;
            zero_reg    <= 1'b0;
            cnt_reg     <= CNT_LOAD;
            if (dec_illegal) begin
              // Rejected words skip execution; Control keeps its old value
              state_reg <= ST_RESP;
            end else begin
              ctl_reg   <= dec_control;
              state_reg <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_WRITE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        ST_WRITE: begin
          // Zero reflects the operands still presented during write-back
          zero_reg  <= Zero;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and pulse outputs decoded from the current state
  always_comb begin
    InstrReady = (state_reg == ST_IDLE);
    RegWrite   = (state_reg == ST_WRITE) && (rd_reg != 5'd0);
    DoneValid  = (state_reg == ST_RESP);
  end

  assign ReadReg1 = rs1_reg;
  assign ReadReg2 = rs2_reg;
  assign WriteReg = rd_reg;
  assign Control  = ctl_reg;
  assign DoneZero = zero_reg;
  assign Illegal  = illegal_reg;

endmodule

// File: tb/tb_alu_issue_controller.sv
// Scoreboard bench for alu_issue_controller. Two instances (EXEC_CYCLES 1 and
// 3) each get a driver that pushes expected completions into a queue and a
// monitor that pops and compares whenever RegWrite or DoneValid appears.
module tb_alu_issue_controller;

  int  checks = 0;
  int  errors = 0;
  int  fin_cnt = 0;
  logic clk = 1'b0;

  always #5 clk = ~clk;

  typedef struct {
    int done_cyc;
    int rs1;
    int rs2;
    int rd;
    int ctl;
    bit ill;
    bit zero;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference decode from the instruction-set table; -1 means rejected
  function automatic int ref_ctl(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op != 7'h33) return -1;
    if (f3 == 3'd0 && f7 == 7'h00) return 2;
    if (f3 == 3'd0 && f7 == 7'h20) return 6;
    if (f3 == 3'd7 && f7 == 7'h00) return 0;
    if (f3 == 3'd6 && f7 == 7'h00) return 1;
    if (f3 == 3'd2 && f7 == 7'h00) return 7;
    return -1;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [4:0]  rd;
    int k;
    rd = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 7) == 0) rd = 5'd0;
    k = $urandom_range(0, 7);
    w = {7'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 3'd0, rd, 7'h33};
    case (k)
      0: w[14:12] = 3'd0;
      1: begin w[14:12] = 3'd0; w[31:25] = 7'h20; end
      2: w[14:12] = 3'd7;
      3: w[14:12] = 3'd6;
      4: w[14:12] = 3'd2;
      5: begin
        w[6:0] = 7'($urandom_range(0, 127));
        if (w[6:0] == 7'h33) w[6:0] = 7'h13;
      end
      6: w[31:25] = 7'h01;
      default: w[14:12] = 3'(1 + 2 * $urandom_range(0, 1));
    endcase
    return w;
  endfunction

  localparam int NTX = 60;

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int E = (gi == 0) ? 1 : 3;

    logic        Reset;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic        Zero;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [3:0]  Control;
    logic        RegWrite;
    logic        DoneValid;
    logic        DoneZero;
    logic        Illegal;

    int   cyc = 0;
    exp_t q[$];
    int   rw_cyc_q[$];
    int   rw_rd_q[$];
    int   ctl_last = 0;
    int   prev_done = -100;
    bit   held = 1'b0;

    alu_issue_controller #(.EXEC_CYCLES(E)) dut (
      .Clk        (clk),
      .Reset      (Reset),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .Instr      (Instr),
      .Zero       (Zero),
      .ReadReg1   (ReadReg1),
      .ReadReg2   (ReadReg2),
      .WriteReg   (WriteReg),
      .Control    (Control),
      .RegWrite   (RegWrite),
      .DoneValid  (DoneValid),
      .DoneZero   (DoneZero),
      .Illegal    (Illegal)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic gchk(input string n, input logic [31:0] a, input logic [31:0] e);
      chk($sformatf("E%0d_%s", E, n), a, e);
    endtask

    task automatic check_reset_outputs(input string tag);
      gchk({tag, "_ready"}, InstrReady, 1);
      gchk({tag, "_regwrite"}, RegWrite, 0);
      gchk({tag, "_done"}, DoneValid, 0);
      gchk({tag, "_rr1"}, ReadReg1, 0);
      gchk({tag, "_rr2"}, ReadReg2, 0);
      gchk({tag, "_wr"}, WriteReg, 0);
      gchk({tag, "_ctl"}, Control, 0);
      gchk({tag, "_illegal"}, Illegal, 0);
      gchk({tag, "_donezero"}, DoneZero, 0);
    endtask

    // Present one word, wait for acceptance, schedule its expected results
    // and drive Zero so that only the write-back cycle carries value z.
    task automatic issue(input logic [31:0] w, input bit z);
      int   waited;
      int   c;
      int   ctl;
      exp_t e;
      Instr      = w;
      InstrValid = 1'b1;
      Zero       = !z;
      waited     = 0;
      while (!InstrReady && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      if (!InstrReady) begin
        gchk("accept_timeout", InstrReady, 1);
        return;
      end
      c = cyc;
      if (held) gchk("b2b_accept_cycle", c, prev_done + 1);
      ctl = ref_ctl(w);
      if (ctl >= 0) ctl_last = ctl;
      e.done_cyc = (ctl >= 0) ? c + E + 2 : c + 1;
      e.rs1  = int'(w[19:15]);
      e.rs2  = int'(w[24:20]);
      e.rd   = int'(w[11:7]);
      e.ctl  = ctl_last;
      e.ill  = (ctl < 0);
      e.zero = z;
      q.push_back(e);
      if (ctl >= 0 && w[11:7] != 5'd0) begin
        rw_cyc_q.push_back(c + E + 1);
        rw_rd_q.push_back(int'(w[11:7]));
      end
      prev_done = e.done_cyc;
      @(negedge clk);
      if (ctl >= 0) begin
        repeat (E) @(negedge clk);
        Zero = z;
        @(negedge clk);
        Zero = !z;
      end
    endtask

    // Monitor: compare every completion and write pulse with the scoreboard
    always @(negedge clk) begin : mon
      exp_t e;
      int   wc;
      int   wd;
      if (!Reset) begin
        if (DoneValid) begin
          if (q.size() == 0) begin
            gchk("done_unexpected", DoneValid, 0);
          end else begin
            e = q.pop_front();
            gchk("done_cycle", cyc, e.done_cyc);
            gchk("done_rr1", ReadReg1, e.rs1);
            gchk("done_rr2", ReadReg2, e.rs2);
            gchk("done_wr", WriteReg, e.rd);
            gchk("done_ctl", Control, e.ctl);
            gchk("done_illegal", Illegal, e.ill);
            gchk("done_ready_low", InstrReady, 0);
            if (!e.ill) gchk("done_zero", DoneZero, e.zero);
            $display("E%0d cyc=%0d done rd=%0d ctl=%0d illegal=%0d zero=%0d",
                     E, cyc, WriteReg, Control, Illegal, DoneZero);
          end
        end
        if (RegWrite) begin
          if (rw_cyc_q.size() == 0) begin
            gchk("regwrite_unexpected", RegWrite, 0);
          end else begin
            wc = rw_cyc_q.pop_front();
            wd = rw_rd_q.pop_front();
            gchk("regwrite_cycle", cyc, wc);
            gchk("regwrite_rd", WriteReg, wd);
          end
        end
      end
    end

    initial begin : drv
      logic [31:0] dir_words [4];
      logic [31:0] w;
      bit          z;
      int          guard;
      int          bad;
      dir_words[0] = 32'h002081B3;   // ADD x3,x1,x2
      dir_words[1] = 32'h404202B3;   // SUB x5,x4,x4
      dir_words[2] = 32'h00208033;   // ADD x0,x1,x2
      dir_words[3] = 32'h00310093;   // ADDI (I-type, rejected)
      Reset      = 1'b1;
      InstrValid = 1'b0;
      Instr      = '0;
      Zero       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      Reset = 1'b0;

      for (int n = 0; n < NTX; n++) begin
        w = (n < 4) ? dir_words[n] : rand_word();
        z = (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        issue(w, z);
        if ($urandom_range(0, 2) == 0) begin
          InstrValid = 1'b0;
          held = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end else begin
          held = 1'b1;
        end
      end

      // Let outstanding work complete before the reset scenario
      InstrValid = 1'b0;
      held  = 1'b0;
      guard = 0;
      while ((q.size() != 0 || rw_cyc_q.size() != 0) && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      gchk("drain_done_q", q.size(), 0);
      gchk("drain_rw_q", rw_cyc_q.size(), 0);

      // Two ADDs with valid held; reset lands in the second one's EXEC phase
      issue(32'h002081B3, 1'b0);
      held       = 1'b1;
      Instr      = 32'h00208333;      // ADD x6,x1,x2
      InstrValid = 1'b1;
      guard      = 0;
      while (!InstrReady && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      gchk("b2b_second_accept", cyc, prev_done + 1);
      @(negedge clk);
      Reset      = 1'b1;
      InstrValid = 1'b0;
      @(negedge clk);
      Reset    = 1'b0;
      ctl_last = 0;
      check_reset_outputs("midreset");
      bad = 0;
      repeat (E + 4) begin
        @(negedge clk);
        if (RegWrite || DoneValid) bad++;
      end
      gchk("no_activity_after_reset", bad, 0);
      fin_cnt++;
    end
  end

  initial begin : summary
    int guard;
    guard = 0;
    while (fin_cnt < 2 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (fin_cnt < 2) chk("finish_timeout", fin_cnt, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
